// File: rtl/vga_pkg.sv
// Shared constants, colours, motion FSM encoding and the per-axis bounce rule.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    // RGB332 colours: {R[2:0], G[2:0], B[1:0]}
    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_BLUE  = 8'h03;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_UPD_X = 2'd1,
        S_UPD_Y = 2'd2,
        S_DONE  = 2'd3
    } motion_state_e;

    // One axis step with bounce. back=0 moves towards the limit, back=1 towards 0.
    // Arithmetic is 11 bits wide so pos+step and pos-step never wrap.
    // Returns {new_back, new_pos}.
    function automatic logic [10:0] axis_next(input logic [9:0]  pos,
                                              input logic        back,
                                              input logic [10:0] step,
                                              input logic [10:0] limit);
        logic [10:0] p;
        logic [10:0] r;
        p = {1'b0, pos};
        r = {back, pos};
        if (!back) begin
            if (p + step >= limit) r = {1'b1, limit[9:0]};
            else                   r = {1'b0, 10'(p + step)};
        end else begin
            if (p < step) r = {1'b0, 10'd0};
            else          r = {1'b1, 10'(p - step)};
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_sprite_render_if.sv
// Pixel stream into the sprite renderer and the delayed colour/sync stream out.
// The stream has no backpressure: every clock carries one pixel position, and the
// colour/sync for it appear exactly two clocks later; o_frame is a one-clock strobe.
interface vga_sprite_render_if;
    import vga_pkg::*;

    logic          i_hsync;
    logic          i_vsync;
    logic [9:0]    i_h_CNT;
    logic [9:0]    i_v_CNT;
    logic          i_VideoEnable;
    logic          i_pause;

    logic          o_hsync;
    logic          o_vsync;
    logic [7:0]    o_rgb;
    logic          o_frame;

    // Observation of the motion block
    motion_state_e dbg_state;
    logic [9:0]    dbg_x;
    logic [9:0]    dbg_y;
    logic          dbg_dir_x;
    logic          dbg_dir_y;

    modport master (
        output i_hsync, i_vsync, i_h_CNT, i_v_CNT, i_VideoEnable, i_pause,
        input  o_hsync, o_vsync, o_rgb, o_frame,
        input  dbg_state, dbg_x, dbg_y, dbg_dir_x, dbg_dir_y
    );

    modport slave (
        input  i_hsync, i_vsync, i_h_CNT, i_v_CNT, i_VideoEnable, i_pause,
        output o_hsync, o_vsync, o_rgb, o_frame,
        output dbg_state, dbg_x, dbg_y, dbg_dir_x, dbg_dir_y
    );
endinterface

// File: rtl/sprite_motion.sv
// Sprite position/direction registers, stepped once per frame tick by a small FSM.
module sprite_motion
    import vga_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int STEP = 2,
    parameter int X0   = 100,
    parameter int Y0   = 50
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          tick,
    input  logic          pause,
    output logic [9:0]    x,
    output logic [9:0]    y,
    output logic          dir_x,   // 0 = right, 1 = left
    output logic          dir_y,   // 0 = down,  1 = up
    output logic          frame,
    output motion_state_e state
);

    localparam int X_LIM = H_DISPLAY - SIZE;
    localparam int Y_LIM = V_DISPLAY - SIZE;

    motion_state_e state_d;
    logic [10:0]   x_next;
    logic [10:0]   y_next;

    assign x_next = axis_next(x, dir_x, 11'(STEP), 11'(X_LIM));
    assign y_next = axis_next(y, dir_y, 11'(STEP), 11'(Y_LIM));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_WAIT;
        else       state <= state_d;
    end

    // Next state: ticks outside S_WAIT are dropped, not queued
    always_comb begin
        state_d = state;
        case (state)
            S_WAIT:  if (tick) state_d = S_UPD_X;
            S_UPD_X: state_d = S_UPD_Y;
            S_UPD_Y: state_d = S_DONE;
            S_DONE:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // Position/direction: one axis per update state, frozen while paused
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x     <= 10'(X0);
            y     <= 10'(Y0);
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (!pause) begin
            if (state == S_UPD_X) {dir_x, x} <= x_next;
            if (state == S_UPD_Y) {dir_y, y} <= y_next;
        end
    end

    // Frame strobe: registered, so it is high the clock after S_DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) frame <= 1'b0;
        else       frame <= (state == S_DONE);
    end

endmodule

// File: rtl/vga_sprite_render.sv
// Two-stage pixel pipeline drawing a bouncing square sprite over a bordered background.
module vga_sprite_render
    import vga_pkg::*;
#(
    parameter int         SIZE   = 32,
    parameter int         STEP   = 2,
    parameter int         X0     = 100,
    parameter int         Y0     = 50,
    parameter logic [7:0] FG     = RGB_RED,
    parameter logic [7:0] BORDER = RGB_WHITE,
    parameter logic [7:0] BG     = RGB_BLUE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    vga_sprite_render_if.slave bus
);

    logic [9:0] s1_col, s1_row;
    logic       s1_en, s1_hs, s1_vs;
    logic       vs_prev, vs_armed;
    logic       tick;

    logic [9:0] pos_x, pos_y;
    logic       dir_x, dir_y;

    logic       sprite_hit, border_hit;
    logic [7:0] rgb_d;
    logic [7:0] rgb_q;
    logic       hs_q, vs_q;

    // Stage 1: register position, enable and syncs; track vsync history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_col   <= '0;
            s1_row   <= '0;
            s1_en    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            vs_prev  <= 1'b0;
            vs_armed <= 1'b0;
        end else begin
            s1_col   <= bus.i_h_CNT;
            s1_row   <= bus.i_v_CNT;
            s1_en    <= bus.i_VideoEnable;
            s1_hs    <= bus.i_hsync;
            s1_vs    <= bus.i_vsync;
            vs_prev  <= s1_vs;
            // Only arm after vsync has been seen low, so a vsync already high
            // when reset drops does not look like a new frame.
            vs_armed <= vs_armed | ~bus.i_vsync;
        end
    end

    assign tick = s1_vs & ~vs_prev & vs_armed;

    sprite_motion #(
        .SIZE (SIZE),
        .STEP (STEP),
        .X0   (X0),
        .Y0   (Y0)
    ) u_motion (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .tick  (tick),
        .pause (bus.i_pause),
        .x     (pos_x),
        .y     (pos_y),
        .dir_x (dir_x),
        .dir_y (dir_y),
        .frame (bus.o_frame),
        .state (bus.dbg_state)
    );

    // Hit tests on the stage-1 position and colour priority mux
    always_comb begin
        sprite_hit = ({1'b0, s1_col} >= {1'b0, pos_x}) &&
                     ({1'b0, s1_col} <  {1'b0, pos_x} + 11'(SIZE)) &&
                     ({1'b0, s1_row} >= {1'b0, pos_y}) &&
                     ({1'b0, s1_row} <  {1'b0, pos_y} + 11'(SIZE));
        border_hit = (s1_col == 10'd0) || (s1_col == 10'(H_DISPLAY - 1)) ||
                     (s1_row == 10'd0) || (s1_row == 10'(V_DISPLAY - 1));
        rgb_d = BG;
        if (!s1_en)          rgb_d = RGB_BLACK;
        else if (sprite_hit) rgb_d = FG;
        else if (border_hit) rgb_d = BORDER;
    end

    // Stage 2: colour and syncs leave together
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q <= RGB_BLACK;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= s1_hs;
            vs_q  <= s1_vs;
        end
    end

    assign bus.o_rgb     = rgb_q;
    assign bus.o_hsync   = hs_q;
    assign bus.o_vsync   = vs_q;
    assign bus.dbg_x     = pos_x;
    assign bus.dbg_y     = pos_y;
    assign bus.dbg_dir_x = dir_x;
    assign bus.dbg_dir_y = dir_y;

endmodule

// File: tb/tb_vga_sprite_render.sv
// Bench for vga_sprite_render: directed pixels and frame ticks, expectations queued
// with the cycle they fall due, checked by an independent monitor.
module tb_vga_sprite_render;
    import vga_pkg::*;

    localparam int K_RGB   = 0;
    localparam int K_STATE = 1;
    localparam int K_FRAME = 2;
    localparam int K_Y2    = 3;

    typedef struct packed {
        int         due;
        int         kind;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic [1:0] st;
        logic [9:0] x;
        logic [9:0] y;
        logic       dir;
        logic       chk;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    vga_sprite_render_if bus ();
    vga_sprite_render_if bus2 ();

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sprite_render dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Second instance with an odd limit (480-33=447) so the upward run reaches y=1
    vga_sprite_render #(.SIZE(33), .Y0(445)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    assign bus2.i_hsync       = bus.i_hsync;
    assign bus2.i_h_CNT       = bus.i_h_CNT;
    assign bus2.i_v_CNT       = bus.i_v_CNT;
    assign bus2.i_VideoEnable = bus.i_VideoEnable;
    assign bus2.i_pause       = bus.i_pause;

    function automatic exp_t mk(input int due, input int kind, input logic [7:0] rgb,
                                input logic hs, input logic vs, input logic [1:0] st,
                                input logic [9:0] x, input logic [9:0] y,
                                input logic dir, input logic chk);
        exp_t e;
        e.due = due; e.kind = kind; e.rgb = rgb; e.hs = hs; e.vs = vs;
        e.st = st; e.x = x; e.y = y; e.dir = dir; e.chk = chk;
        return e;
    endfunction

    // ---------------- driver tasks (enter and leave on a falling edge) ----------------
    task automatic pix(input logic [9:0] col, input logic [9:0] row, input logic en,
                       input logic hs, input logic [7:0] exp_rgb);
        bus.i_h_CNT       = col;
        bus.i_v_CNT       = row;
        bus.i_VideoEnable = en;
        bus.i_hsync       = hs;
        exp_q.push_back(mk(cyc + 2, K_RGB, exp_rgb, hs, bus.i_vsync, 2'd0, 10'd0, 10'd0, 1'b0, 1'b1));
        @(negedge clk);
    endtask

    task automatic tick1(input logic chk, input logic [9:0] ex, input logic [9:0] ey,
                         input logic edir);
        bus.i_vsync = 1'b1;
        exp_q.push_back(mk(cyc + 5, K_FRAME, 8'h00, 1'b0, 1'b0, 2'd0, ex, ey, edir, chk));
        @(negedge clk);
        bus.i_vsync = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic tick2(input logic chk, input logic [9:0] ey, input logic edir);
        bus2.i_vsync = 1'b1;
        if (chk) exp_q.push_back(mk(cyc + 5, K_Y2, 8'h00, 1'b0, 1'b0, 2'd0, 10'd0, ey, edir, 1'b1));
        @(negedge clk);
        bus2.i_vsync = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic frame_ok;
        frame_ok = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (e.due < cyc) begin
                n_bad++;
                $display("FAIL missed: kind %0d due %0d checked at %0d", e.kind, e.due, cyc);
            end else begin
                case (e.kind)
                    K_RGB: begin
                        if ({bus.o_rgb, bus.o_hsync, bus.o_vsync} !== {e.rgb, e.hs, e.vs}) begin
                            n_bad++;
                            $display("FAIL rgb @%0d: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                                     cyc, bus.o_rgb, bus.o_hsync, bus.o_vsync, e.rgb, e.hs, e.vs);
                        end
                    end
                    K_STATE: begin
                        if ({2'(bus.dbg_state), bus.dbg_x, bus.dbg_y, bus.o_frame} !== {e.st, e.x, e.y, 1'b0}) begin
                            n_bad++;
                            $display("FAIL state @%0d: got st=%0d x=%0d y=%0d frame=%b, want st=%0d x=%0d y=%0d frame=0",
                                     cyc, bus.dbg_state, bus.dbg_x, bus.dbg_y, bus.o_frame, e.st, e.x, e.y);
                        end
                    end
                    K_FRAME: begin
                        frame_ok = 1'b1;
                        if (bus.o_frame !== 1'b1 ||
                            (e.chk && {bus.dbg_x, bus.dbg_y, bus.dbg_dir_x} !== {e.x, e.y, e.dir})) begin
                            n_bad++;
                            $display("FAIL frame @%0d: got frame=%b x=%0d y=%0d dir_x=%b, want frame=1 x=%0d y=%0d dir_x=%b (pos checked=%b)",
                                     cyc, bus.o_frame, bus.dbg_x, bus.dbg_y, bus.dbg_dir_x, e.x, e.y, e.dir, e.chk);
                        end
                    end
                    default: begin
                        if ({bus2.o_frame, bus2.dbg_y, bus2.dbg_dir_y} !== {1'b1, e.y, e.dir}) begin
                            n_bad++;
                            $display("FAIL y_bounce @%0d: got frame=%b y=%0d dir_y=%b, want frame=1 y=%0d dir_y=%b",
                                     cyc, bus2.o_frame, bus2.dbg_y, bus2.dbg_dir_y, e.y, e.dir);
                        end
                    end
                endcase
            end
        end
        if (bus.o_frame === 1'b1 && !frame_ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame @%0d: got o_frame=1, want 0", cyc);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout: simulation did not finish, got cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst               = 1'b1;
        bus.i_hsync       = 1'b0;
        bus.i_vsync       = 1'b1;   // high across reset: must not produce a tick
        bus.i_h_CNT       = 10'd0;
        bus.i_v_CNT       = 10'd0;
        bus.i_VideoEnable = 1'b0;
        bus.i_pause       = 1'b0;
        bus2.i_vsync      = 1'b0;

        @(negedge clk);
        exp_q.push_back(mk(cyc + 1, K_STATE, 8'h00, 1'b0, 1'b0, 2'(S_WAIT), 10'd100, 10'd50, 1'b0, 1'b1));
        exp_q.push_back(mk(cyc + 1, K_RGB, 8'h00, 1'b0, 1'b0, 2'd0, 10'd0, 10'd0, 1'b0, 1'b1));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        bus.i_vsync = 1'b0;
        repeat (3) @(negedge clk);

        // Sprite at (100,50), 32x32
        pix(10'd110, 10'd60,  1'b1, 1'b1, 8'hE0);
        pix(10'd0,   10'd200, 1'b1, 1'b0, 8'hFF);
        pix(10'd300, 10'd300, 1'b1, 1'b1, 8'h03);
        pix(10'd110, 10'd60,  1'b0, 1'b0, 8'h00);
        pix(10'd639, 10'd100, 1'b1, 1'b1, 8'hFF);
        pix(10'd300, 10'd479, 1'b1, 1'b0, 8'hFF);
        pix(10'd99,  10'd60,  1'b1, 1'b0, 8'h03);
        pix(10'd131, 10'd81,  1'b1, 1'b1, 8'hE0);
        pix(10'd132, 10'd60,  1'b1, 1'b1, 8'h03);
        pix(10'd110, 10'd82,  1'b1, 1'b0, 8'h03);
        pix(10'd100, 10'd50,  1'b1, 1'b0, 8'hE0);
        repeat (3) @(negedge clk);

        // First frame: (102,52)
        tick1(1'b1, 10'd102, 10'd52, 1'b0);
        pix(10'd102, 10'd52, 1'b1, 1'b0, 8'hE0);
        pix(10'd101, 10'd52, 1'b1, 1'b0, 8'h03);
        pix(10'd133, 10'd83, 1'b1, 1'b1, 8'hE0);
        pix(10'd134, 10'd83, 1'b1, 1'b0, 8'h03);
        pix(10'd133, 10'd84, 1'b1, 1'b0, 8'h03);
        repeat (3) @(negedge clk);

        // Run x up to 606; y bounces off 448 at tick 199 and is 340 at tick 253
        for (int i = 2; i <= 252; i++) tick1(1'b0, 10'd0, 10'd0, 1'b0);
        tick1(1'b1, 10'd606, 10'd340, 1'b0);
        tick1(1'b1, 10'd608, 10'd338, 1'b1);
        // Sprite wins over the right border column
        pix(10'd639, 10'd338, 1'b1, 1'b0, 8'hE0);
        repeat (3) @(negedge clk);
        tick1(1'b1, 10'd606, 10'd336, 1'b1);

        // Paused frames still strobe but hold position
        bus.i_pause = 1'b1;
        for (int i = 0; i < 3; i++) tick1(1'b1, 10'd606, 10'd336, 1'b1);
        bus.i_pause = 1'b0;

        // Long vsync high: a single tick
        bus.i_vsync = 1'b1;
        exp_q.push_back(mk(cyc + 5, K_FRAME, 8'h00, 1'b0, 1'b0, 2'd0, 10'd604, 10'd334, 1'b1, 1'b1));
        repeat (1000) @(negedge clk);
        bus.i_vsync = 1'b0;
        repeat (8) @(negedge clk);

        // Reset while in S_UPD_X: no partial update, no frame strobe
        bus.i_vsync = 1'b1;
        exp_q.push_back(mk(cyc + 2, K_STATE, 8'h00, 1'b0, 1'b0, 2'(S_UPD_X), 10'd604, 10'd334, 1'b0, 1'b1));
        @(negedge clk);
        bus.i_vsync = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(mk(cyc + 1, K_STATE, 8'h00, 1'b0, 1'b0, 2'(S_WAIT), 10'd100, 10'd50, 1'b0, 1'b1));
        exp_q.push_back(mk(cyc + 1, K_RGB, 8'h00, 1'b0, 1'b0, 2'd0, 10'd0, 10'd0, 1'b0, 1'b1));
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Y bounce on the second instance: 445 -> 447 (up), then 445..1, 0 (down), 2
        tick2(1'b1, 10'd447, 1'b1);
        for (int i = 2; i <= 223; i++) tick2(1'b0, 10'd0, 1'b0);
        tick2(1'b1, 10'd1, 1'b1);
        tick2(1'b1, 10'd0, 1'b0);
        tick2(1'b1, 10'd2, 1'b0);

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sprite_render.md
VGA_SPRITE_RENDER -- requirements
Module: vga_sprite_render

Interface
REQ-001 SHALL have parameter SIZE, default 32, sprite edge length in pixels.
REQ-002 SHALL have parameter STEP, default 2, sprite displacement per axis per frame in pixels.
REQ-003 SHALL have parameters X0, default 100, and Y0, default 50, giving the sprite top-left position after reset.
REQ-004 SHALL have parameters FG, default 8'hE0; BORDER, default 8'hFF; BG, default 8'h03 (RGB332 colours).
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports i_hsync and i_vsync, input, 1 each, raw sync from the timing generator.
REQ-008 SHALL have ports i_h_CNT and i_v_CNT, input, 10 each, current pixel column and row.
REQ-009 SHALL have port i_VideoEnable, input, 1, high inside the 640x480 active area.
REQ-010 SHALL have port i_pause, input, 1, high to freeze sprite motion.
REQ-011 SHALL have ports o_hsync and o_vsync, output, 1 each, sync delayed to align with colour.
REQ-012 SHALL have port o_rgb, output, 8, RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
REQ-013 SHALL have port o_frame, output, 1, one-cycle pulse when the position update completes.

Function
REQ-014 SHALL register inputs in stage 1 (column/row, enable, syncs) and produce o_rgb, o_hsync, o_vsync from stage 2: fixed latency 2 i_clk, identical for colour and sync.
REQ-015 SHALL compute stage-1 hit flags: sprite = col in [x, x+SIZE-1] and row in [y, y+SIZE-1]; border = col 0 or 639, or row 0 or 479.
REQ-016 SHALL select colour with priority: enable low -> 8'h00; sprite -> FG; border -> BORDER; else BG.
REQ-017 SHALL detect a frame tick as a rising edge of registered i_vsync (previous 0, current 1), generating exactly one tick per frame regardless of the clock-to-pixel ratio.
REQ-018 SHALL implement FSM S_WAIT -> S_UPD_X -> S_UPD_Y -> S_DONE -> S_WAIT: S_WAIT leaves on tick; S_UPD_X and S_UPD_Y last one cycle each; S_DONE pulses o_frame for one cycle.
REQ-019 SHALL update position only in S_UPD_X/S_UPD_Y, and only when i_pause is low; when i_pause is high the FSM still cycles and o_frame still pulses.
REQ-020 SHALL apply the X rule in S_UPD_X: moving right with x+STEP >= 640-SIZE -> x=640-SIZE, direction becomes left; moving left with x < STEP -> x=0, direction becomes right; else x +/- STEP.
REQ-021 SHALL apply the Y rule in S_UPD_Y identically, with limit 480-SIZE and directions down/up.
REQ-022 SHALL keep x and y 10-bit unsigned, performing comparisons at 11 bits so that no wrap-around occurs.
REQ-023 SHALL ignore a tick arriving in any state other than S_WAIT (no queuing).
REQ-024 SHALL keep position constant during active video, since updates occur only in vertical retrace.

Reset
REQ-025 SHALL, on i_rst high at a clock edge: FSM=S_WAIT, x=X0, y=Y0, direction right/down, pipeline cleared, o_rgb=8'h00, o_hsync=0, o_vsync=0, o_frame=0, vsync edge register=0.
REQ-026 SHALL take reset effect mid-frame or mid-update on the next edge, with no partial position update retained.
REQ-027 SHALL NOT generate a spurious tick on the first edge after reset, even if i_vsync is already high.

Structure
REQ-028 SHALL place the shared package vga_pkg with H_DISPLAY=640, V_DISPLAY=480, the RGB332 colour constants and the FSM state encoding.
REQ-029 SHALL have one sub-module, sprite_motion (FSM plus position/direction registers), instantiated once; the pipeline and colour mux SHALL reside in the top module.

Verification
REQ-030 SHALL verify: reset, then col=110, row=60, enable=1 -> o_rgb=8'hE0 exactly 2 cycles later; col=0, row=200 -> 8'hFF; col=300, row=300 -> 8'h03; enable=0 -> 8'h00.
REQ-031 SHALL verify: one vsync rising edge after reset -> o_frame pulses once 4 cycles after the edge cycle; x=102, y=52.
REQ-032 SHALL verify: x forced to 606 moving right, one tick -> x=608 (=640-32), direction left; next tick -> x=606.
REQ-033 SHALL verify: y=1 moving up, one tick -> y=0, direction down; next tick -> y=2.
REQ-034 SHALL verify: i_pause=1 over 3 ticks -> 3 o_frame pulses, x and y unchanged; vsync held high for 1000 cycles -> exactly one tick.
REQ-035 SHALL verify: i_rst asserted in S_UPD_X -> next cycle FSM=S_WAIT, x=100, y=50, o_frame=0.
